// File: rtl/mmio_defs.sv
// Shared address map, bus constants and seven-segment glyph table for the
// memory-mapped I/O bridge.
package mmio_defs;

    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;

    // Word-aligned offsets inside the 4 KiB peripheral window
    localparam logic [11:0] OFF_DISP = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}, decimal point off
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment driver: cycles one digit at a time and
// decodes the matching nibble of the display register.
module seg_scan #(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] disp,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    import mmio_defs::*;

    localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
        end
    end

    assign dig_en  = ~(8'h01 << idx_q);
    assign dig_seg = hex_to_seg(disp[{idx_q, 2'b00} +: 4]);

endmodule

// File: rtl/mmio_bridge.sv
// CPU data-bus responder: routes each access to DRAM or to the memory-mapped
// LED, switch, button, display and timer registers.
module mmio_bridge #(
    parameter int          SCAN_DIV    = 20000,
    parameter logic [31:0] PERIPH_BASE = mmio_defs::PERIPH_BASE
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    import mmio_defs::*;

    logic        is_periph;
    logic [11:0] off;
    logic        pwr;

    logic [31:0] disp_q, disp_d;
    logic [23:0] led_q, led_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tdiv_q, tdiv_d;
    logic [31:0] presc_q, presc_d;
    logic [23:0] sw_meta_q, sw_sync_q;
    logic [4:0]  btn_meta_q, btn_sync_q;
    logic [31:0] periph_rdata;

    assign is_periph = (Bus_addr[31:12] == PERIPH_BASE[31:12]);
    assign off       = {Bus_addr[11:2], 2'b00};
    assign pwr       = Bus_wen & is_periph;

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wen   = Bus_wen & ~is_periph;
    assign dram_wdata = Bus_wdata;

    always_comb begin
        disp_d  = disp_q;
        led_d   = led_q;
        tdiv_d  = tdiv_q;
        tcnt_d  = tcnt_q;
        presc_d = presc_q + 32'd1;
        if (presc_q == tdiv_q) begin
            presc_d = '0;
            tcnt_d  = tcnt_q + 32'd1;
        end
        if (pwr) begin
            case (off)
                OFF_DISP: disp_d = Bus_wdata;
                OFF_LED:  led_d  = Bus_wdata[23:0];
                // A CNT load overrides any tick landing in the same cycle
                OFF_TCNT: begin
                    tcnt_d  = Bus_wdata;
                    presc_d = '0;
                end
                OFF_TDIV: begin
                    tdiv_d  = Bus_wdata;
                    presc_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            disp_q     <= '0;
            led_q      <= '0;
            tcnt_q     <= '0;
            tdiv_q     <= '0;
            presc_q    <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            disp_q     <= disp_d;
            led_q      <= led_d;
            tcnt_q     <= tcnt_d;
            tdiv_q     <= tdiv_d;
            presc_q    <= presc_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= button;
            btn_sync_q <= btn_meta_q;
        end
    end

    always_comb begin
        periph_rdata = '0;
        case (off)
            OFF_DISP: periph_rdata = disp_q;
            OFF_TCNT: periph_rdata = tcnt_q;
            OFF_TDIV: periph_rdata = tdiv_q;
            OFF_LED:  periph_rdata = {8'h00, led_q};
            OFF_SW:   periph_rdata = {8'h00, sw_sync_q};
            OFF_BTN:  periph_rdata = {27'h0, btn_sync_q};
            default:  ;
        endcase
    end

    // Combinational return path: the single-cycle CPU consumes it this cycle
    assign Bus_rdata = is_periph ? periph_rdata : dram_rdata;
    assign led       = led_q;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .disp      (disp_q),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
    );

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge against a cycle-count based reference
// model of the register map, timer and display scan.
module tb_mmio_bridge;

    localparam int SCAN_DIV = 4;
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, dram_rdata, dram_wdata;
    logic        bus_wen, dram_wen;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [4:0]  button;
    logic [7:0]  dig_en, dig_seg;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0]     m_disp, m_div, m_cnt_base;
    logic [23:0]     m_led;
    longint unsigned m_elapsed;
    int              m_scan_edges;
    logic [23:0]     m_sw_hist [2];
    logic [4:0]      m_btn_hist [2];

    always #5 clk = ~clk;

    mmio_bridge #(.SCAN_DIV(SCAN_DIV)) dut (
        .cpu_clk    (clk),
        .cpu_rst_n  (rst_n),
        .Bus_addr   (bus_addr),
        .Bus_wen    (bus_wen),
        .Bus_wdata  (bus_wdata),
        .Bus_rdata  (bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    function automatic logic [31:0] m_cnt_after(input longint unsigned cycles);
        longint unsigned t;
        t = {32'h0, m_cnt_base} + cycles / ({32'h0, m_div} + 64'd1);
        return t[31:0];
    endfunction

    function automatic bit m_is_periph(input logic [31:0] a);
        return (a >> 12) == 32'h000F_FFFF;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_is_periph(a)) return dram_rdata;
        case (a & 32'hFFC)
            32'h000: return m_disp;
            32'h020: return m_cnt_after(m_elapsed);
            32'h024: return m_div;
            32'h060: return {8'h0, m_led};
            32'h070: return {8'h0, m_sw_hist[1]};
            32'h078: return {27'h0, m_btn_hist[1]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] m_dig_en();
        int idx;
        idx = (m_scan_edges / SCAN_DIV) % 8;
        return 8'hFF ^ 8'(1 << idx);
    endfunction

    function automatic logic [7:0] m_dig_seg();
        int idx;
        logic [31:0] sh;
        idx = (m_scan_edges / SCAN_DIV) % 8;
        sh  = m_disp >> (4 * idx);
        return GLYPH[sh[3:0]];
    endfunction

    task automatic model_reset();
        m_disp       = '0;
        m_div        = '0;
        m_cnt_base   = '0;
        m_led        = '0;
        m_elapsed    = 0;
        m_scan_edges = 0;
        m_sw_hist    = '{default: '0};
        m_btn_hist   = '{default: '0};
    endtask

    // Advance the model by one rising edge using the bus values now applied
    task automatic model_edge();
        bit timer_written = 0;
        if (bus_wen && m_is_periph(bus_addr)) begin
            case (bus_addr & 32'hFFC)
                32'h000: m_disp = bus_wdata;
                32'h060: m_led  = bus_wdata[23:0];
                32'h020: begin
                    m_cnt_base    = bus_wdata;
                    m_elapsed     = 0;
                    timer_written = 1;
                end
                32'h024: begin
                    m_cnt_base    = m_cnt_after(m_elapsed + 1);
                    m_div         = bus_wdata;
                    m_elapsed     = 0;
                    timer_written = 1;
                end
                default: ;
            endcase
        end
        if (!timer_written) m_elapsed++;
        m_sw_hist[1]  = m_sw_hist[0];
        m_sw_hist[0]  = sw;
        m_btn_hist[1] = m_btn_hist[0];
        m_btn_hist[0] = button;
        m_scan_edges++;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus_addr  = a;
        bus_wen   = w;
        bus_wdata = d;
        #1;
    endtask

    task automatic clock_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(32'hFFFF_F024, 1'b1, 32'd100);
        clock_cycle();
        drive(32'hFFFF_F020, 1'b1, 32'd5);
        clock_cycle();
        drive(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF);
        clock_cycle();
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        clock_cycle();
        n_cmp++;
        if (bus_rdata !== 32'd5) begin
            n_err++; $display("FAIL pre_reset_cnt: got %h want %h", bus_rdata, 32'd5);
        end
        async_reset();
        n_cmp++;
        if (led !== 24'h0) begin
            n_err++; $display("FAIL reset_led: got %h want %h", led, 24'h0);
        end
        n_cmp++;
        if (dig_en !== 8'hFE) begin
            n_err++; $display("FAIL reset_dig_en: got %h want %h", dig_en, 8'hFE);
        end
        n_cmp++;
        if (dig_seg !== 8'hC0) begin
            n_err++; $display("FAIL reset_dig_seg: got %h want %h", dig_seg, 8'hC0);
        end
        n_cmp++;
        if (bus_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_cnt_read: got %h want %h", bus_rdata, 32'h0);
        end
        release_reset();
    endtask

    task automatic test_led_write();
        drive(32'hFFFF_F060, 1'b1, 32'hFFA5_A5A5);
        n_cmp++;
        if (dram_wen !== 1'b0) begin
            n_err++; $display("FAIL led_dram_wen: got %b want 0", dram_wen);
        end
        clock_cycle();
        n_cmp++;
        if (led !== 24'hA5A5A5) begin
            n_err++; $display("FAIL led_value: got %h want %h", led, 24'hA5A5A5);
        end
        drive(32'hFFFF_F060, 1'b0, 32'h0);
        n_cmp++;
        if (bus_rdata !== 32'h00A5_A5A5 || dram_wen !== 1'b0) begin
            n_err++; $display("FAIL led_read: got %h wen %b want %h wen 0", bus_rdata, dram_wen, 32'h00A5_A5A5);
        end
    endtask

    task automatic test_sw_sync();
        sw = 24'hABCDEF;
        drive(32'hFFFF_F070, 1'b0, 32'h0);
        clock_cycle();
        clock_cycle();
        sw = 24'h123456;
        clock_cycle();
        n_cmp++;
        if (bus_rdata !== 32'h00AB_CDEF) begin
            n_err++; $display("FAIL sw_edge1: got %h want %h", bus_rdata, 32'h00AB_CDEF);
        end
        clock_cycle();
        n_cmp++;
        if (bus_rdata !== 32'h0012_3456) begin
            n_err++; $display("FAIL sw_edge2: got %h want %h", bus_rdata, 32'h0012_3456);
        end
    endtask

    task automatic test_display();
        async_reset();
        release_reset();
        drive(32'hFFFF_F000, 1'b1, 32'h89AB_CDEF);
        clock_cycle();
        drive(32'h0000_0000, 1'b0, 32'h0);
        n_cmp++;
        if (dig_en !== 8'hFE || dig_seg !== 8'h8E) begin
            n_err++; $display("FAIL disp_first: got %h/%h want FE/8E", dig_en, dig_seg);
        end
        for (int i = 0; i < 36; i++) begin
            clock_cycle();
            n_cmp++;
            if (dig_en !== m_dig_en() || dig_seg !== m_dig_seg()) begin
                n_err++; $display("FAIL disp_scan[%0d]: got %h/%h want %h/%h", i, dig_en, dig_seg, m_dig_en(), m_dig_seg());
            end
            if (m_scan_edges == 4 || m_scan_edges == 8 || m_scan_edges == 32) begin
                n_cmp++;
                if ((m_scan_edges == 4 && {dig_en, dig_seg} !== 16'hFD86) ||
                    (m_scan_edges == 8 && {dig_en, dig_seg} !== 16'hFBA1) ||
                    (m_scan_edges == 32 && {dig_en, dig_seg} !== 16'hFE8E)) begin
                    n_err++; $display("FAIL disp_point_%0d: got %h/%h", m_scan_edges, dig_en, dig_seg);
                end
            end
        end
    endtask

    task automatic test_timer();
        drive(32'hFFFF_F024, 1'b1, 32'd2);
        clock_cycle();
        drive(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFE);
        clock_cycle();
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        repeat (3) clock_cycle();
        n_cmp++;
        if (bus_rdata !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL timer_3: got %h want %h", bus_rdata, 32'hFFFF_FFFF);
        end
        repeat (3) clock_cycle();
        n_cmp++;
        if (bus_rdata !== 32'h0) begin
            n_err++; $display("FAIL timer_wrap: got %h want %h", bus_rdata, 32'h0);
        end
        repeat (2) clock_cycle();
        drive(32'hFFFF_F020, 1'b1, 32'h10);
        clock_cycle();
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        n_cmp++;
        if (bus_rdata !== 32'h10) begin
            n_err++; $display("FAIL timer_write_vs_tick: got %h want %h", bus_rdata, 32'h10);
        end
        clock_cycle();
        n_cmp++;
        if (bus_rdata !== m_read(32'hFFFF_F020) || bus_rdata !== 32'h10) begin
            n_err++; $display("FAIL timer_after_load: got %h want %h", bus_rdata, 32'h10);
        end
    endtask

    task automatic test_dram_unmapped();
        logic [31:0] d;
        d = $urandom;
        dram_rdata = $urandom;
        drive(32'h0000_0100, 1'b1, d);
        n_cmp++;
        if (dram_wen !== 1'b1 || dram_addr !== 14'h040 || dram_wdata !== d) begin
            n_err++; $display("FAIL dram_write: got wen %b addr %h data %h want 1 040 %h", dram_wen, dram_addr, dram_wdata, d);
        end
        n_cmp++;
        if (bus_rdata !== dram_rdata) begin
            n_err++; $display("FAIL dram_read: got %h want %h", bus_rdata, dram_rdata);
        end
        clock_cycle();
        drive(32'hFFFF_F100, 1'b1, 32'hDEAD_BEEF);
        n_cmp++;
        if (dram_wen !== 1'b0 || bus_rdata !== 32'h0) begin
            n_err++; $display("FAIL unmapped_access: got wen %b data %h want 0 0", dram_wen, bus_rdata);
        end
        clock_cycle();
        drive(32'hFFFF_F060, 1'b0, 32'h0);
        n_cmp++;
        if (bus_rdata !== m_read(32'hFFFF_F060)) begin
            n_err++; $display("FAIL unmapped_led_kept: got %h want %h", bus_rdata, m_read(32'hFFFF_F060));
        end
        drive(32'hFFFF_F000, 1'b0, 32'h0);
        n_cmp++;
        if (bus_rdata !== 32'h89AB_CDEF) begin
            n_err++; $display("FAIL unmapped_disp_kept: got %h want %h", bus_rdata, 32'h89AB_CDEF);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        w;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 8))
                0: a = 32'hFFFF_F000;
                1: a = 32'hFFFF_F020;
                2: a = 32'hFFFF_F024;
                3: a = 32'hFFFF_F060;
                4: a = 32'hFFFF_F070;
                5: a = 32'hFFFF_F078;
                6: a = 32'hFFFF_F000 | ($urandom_range(0, 1023) << 2);
                7: a = $urandom & 32'h0000_FFFF;
                default: a = $urandom;
            endcase
            a = (a & 32'hFFFF_FFFC) | $urandom_range(0, 3);
            w = 1'($urandom_range(0, 1));
            d = ((a & 32'hFFFF_FFFC) == 32'hFFFF_F024) ? $urandom_range(0, 4) : $urandom;
            if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
            if ($urandom_range(0, 7) == 0) button = 5'($urandom);
            dram_rdata = $urandom;
            drive(a, w, d);
            n_cmp++;
            if (bus_rdata !== m_read(a)) begin
                n_err++; $display("FAIL rand_read[%0d] @%h: got %h want %h", i, a, bus_rdata, m_read(a));
            end
            n_cmp++;
            if (dram_wen !== (w && !m_is_periph(a)) || dram_addr !== 14'(a >> 2)) begin
                n_err++; $display("FAIL rand_dram[%0d] @%h: got wen %b addr %h", i, a, dram_wen, dram_addr);
            end
            clock_cycle();
            n_cmp++;
            if (led !== m_led || dig_en !== m_dig_en() || dig_seg !== m_dig_seg()) begin
                n_err++; $display("FAIL rand_outputs[%0d]: got %h %h/%h want %h %h/%h", i, led, dig_en, dig_seg, m_led, m_dig_en(), m_dig_seg());
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus_addr   = '0;
        bus_wen    = 1'b0;
        bus_wdata  = '0;
        dram_rdata = '0;
        sw         = '0;
        button     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_led_write();
        test_sw_sync();
        test_display();
        test_timer();
        test_dram_unmapped();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Responder end of the CPU data bus (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata).
- Decodes every CPU data access. It either passes the access through to DRAM or serves it from memory-mapped peripheral registers: LEDs, switches, buttons, an 8-digit 7-segment display and a free-running timer.
- Reads are combinational, because the single-cycle CPU consumes Bus_rdata in the same cycle. Writes commit on the rising clock edge.

Parameters:
- SCAN_DIV, 20000: cpu_clk cycles each display digit stays enabled (must be ≥1).
- PERIPH_BASE, 32'hFFFF_F000: base of the 4 KiB peripheral window.

Ports:
- cpu_clk  in  1  system clock, the only clock.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- Bus_addr  in  32  CPU byte address.
- Bus_wen  in  1  CPU write enable.
- Bus_wdata  in  32  CPU write data.
- Bus_rdata  out  32  read data returned to the CPU.
- dram_addr  out  14  DRAM word address, Bus_addr[15:2].
- dram_wen  out  1  DRAM write enable.
- dram_wdata  out  32  DRAM write data, Bus_wdata unmodified.
- dram_rdata  in  32  DRAM read data.
- sw  in  24  switches, asynchronous.
- button  in  5  push buttons, asynchronous.
- led  out  24  LED register.
- dig_en  out  8  digit enables, active-low one-hot.
- dig_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Decode:
  - is_periph = (Bus_addr[31:12] == PERIPH_BASE[31:12]).
  - When is_periph is 0, the access targets DRAM: dram_wen = Bus_wen & ~is_periph, and Bus_rdata = dram_rdata.
- Peripheral map (word offsets; Bus_addr[1:0] ignored):
  - 0x000 DISP: R/W, 32-bit display register.
  - 0x020 TIMER_CNT: R/W.
  - 0x024 TIMER_DIV: R/W.
  - 0x060 LED: R/W; bits [23:0] stored, upper bits read as 0.
  - 0x070 SW: read-only, zero-extended.
  - 0x078 BTN: read-only, zero-extended.
- Unmapped peripheral offsets, and writes to SW/BTN:
  - Read returns 0.
  - Write is dropped.
  - dram_wen stays 0.
- Input synchronisation: sw and button each pass through a 2-flop synchroniser. A new input value becomes readable on the 2nd rising edge after it is applied.
- Timer:
  - A prescaler counts 0..TIMER_DIV. When the prescaler equals TIMER_DIV, it returns to 0 and TIMER_CNT increments by 1, i.e. one increment every TIMER_DIV+1 cycles (every cycle when DIV = 0).
  - TIMER_CNT wraps from 0xFFFFFFFF to 0.
  - A write to TIMER_CNT loads Bus_wdata and clears the prescaler. A write in the same cycle as a tick wins over the tick.
  - A write to TIMER_DIV clears the prescaler.
- Display scan:
  - A scan counter counts 0..SCAN_DIV-1. When it wraps, the digit index 0..7 increments, wrapping from 7 to 0.
  - dig_en = ~(1 << idx).
  - dig_seg = hex decode of DISP[4*idx+3:4*idx], with dp off.
  - Hex codes: 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E.
  - dig_en and dig_seg are combinational from the registered idx and DISP.
  - A write to DISP is visible on the currently enabled digit from the next cycle. The scan is not reset by the write.
- Reset (asynchronous, effective immediately, including mid-operation):
  - led = 0, DISP = 0, TIMER_CNT = 0, TIMER_DIV = 0.
  - Prescaler, scan counter, idx and synchroniser flops = 0.
  - Hence dig_en = 8'hFE and dig_seg = 8'hC0 while in reset and after reset.
  - Bus_rdata remains combinational during reset; peripheral reads return the reset values.

Decomposition:
- Shared package, mmio_defs:
  - PERIPH_BASE.
  - Offset constants OFF_DISP, OFF_TCNT, OFF_TDIV, OFF_LED, OFF_SW, OFF_BTN.
  - Segment-code constants.
- Sub-module seg_scan: scan counter, digit index and hex-to-segment decode. Inputs: cpu_clk, cpu_rst_n, DISP value. Outputs: dig_en, dig_seg.

Test Plan:
- Reset check:
  - Stimulus: assert cpu_rst_n = 0 mid-count, with TIMER_CNT = 5 and led = 0xFFFFFF.
  - Required: immediately led = 0, dig_en = 8'hFE, dig_seg = 8'hC0, and a read of 0xFFFF_F020 returns 0.
- LED write:
  - Stimulus: write 0xFFFF_F060 with data 0xFFA5A5A5.
  - Required: after the edge, led = 24'hA5A5A5, a read returns 0x00A5A5A5, and dram_wen = 0 throughout.
- Switch synchronisation:
  - Stimulus: drive sw = 24'h123456 and read 0xFFFF_F070.
  - Required: read returns the old value after the 1st edge and 0x00123456 after the 2nd edge.
- Display scan:
  - Stimulus: SCAN_DIV = 4; write DISP = 0x89ABCDEF.
  - Required sequence:
    - dig_en = FE, dig_seg = 8E.
    - 4 cycles later: FD / 86.
    - Then FB / A1.
    - After 32 cycles: back to FE / 8E.
- Timer:
  - Stimulus: write DIV = 2, then CNT = 0xFFFFFFFE.
  - Required: CNT reads 0xFFFFFFFF 3 cycles later and 0 after 6 cycles. A CNT write of 0x10 coinciding with a tick reads back 0x10.
- DRAM pass-through and unmapped access:
  - Stimulus 1: write 0x0000_0100.
  - Required: dram_wen = 1, dram_addr = 14'h040, dram_wdata = Bus_wdata.
  - Stimulus 2: read 0xFFFF_F100.
  - Required: returns 0, dram_wen = 0, no register changes.
